// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode between fetch and execute.
// The instruction word is decoded combinationally into control fields and an
// XLEN-wide immediate, then captured in one output register guarded by a
// valid/ready handshake. Illegal words deliver a cleared bundle with
// out_illegal set, and a saturating counter tallies delivered illegal words.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_op1_sel,
    output logic             out_op2_sel,
    output logic             out_reg_write_en,
    output logic [1:0]       out_wb_sel,
    output logic             out_mem_write,
    output logic             out_mem_rd_sign_extend,
    output logic [1:0]       out_pc_sel,
    output logic             out_ecall_break,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_imm32;
    logic        d_op1_sel, d_op2_sel, d_reg_write_en, d_mem_write;
    logic        d_sign_ext, d_ecall_break, d_illegal;
    logic [1:0]  d_wb_sel, d_pc_sel;

    // Decode the incoming word; illegal words end up with every control field cleared.
    always_comb begin
        d_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
        d_funct3 = 3'd0; d_funct7 = 7'd0; d_imm32 = 32'd0;
        d_op1_sel = 1'b0; d_op2_sel = 1'b0; d_reg_write_en = 1'b0;
        d_wb_sel = 2'b00; d_mem_write = 1'b0; d_sign_ext = 1'b0;
        d_pc_sel = 2'd0; d_ecall_break = 1'b0; d_illegal = 1'b0;
        case (opcode)
            7'h03: begin
                d_rd = in_instr[11:7]; d_rs1 = in_instr[19:15]; d_funct3 = f3;
                d_imm32 = imm_i; d_op1_sel = 1'b1; d_reg_write_en = 1'b1;
                d_sign_ext = ~f3[2];
                d_illegal = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            7'h23: begin
                d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20]; d_funct3 = f3;
                d_imm32 = imm_s; d_op1_sel = 1'b1; d_mem_write = 1'b1;
                d_illegal = IS64 ? (f3 > 3'b011) : (f3 > 3'b010);
            end
            7'h13, 7'h1B: begin
                d_rd = in_instr[11:7]; d_rs1 = in_instr[19:15]; d_funct3 = f3;
                d_funct7 = (f3 == 3'b001 || f3 == 3'b101) ? in_instr[31:25] : 7'd0;
                d_imm32 = imm_i; d_op1_sel = 1'b1; d_wb_sel = 2'b01;
                d_reg_write_en = 1'b1;
                d_illegal = (opcode == 7'h1B) && !IS64;
            end
            7'h33, 7'h3B: begin
                d_rd = in_instr[11:7]; d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20];
                d_funct3 = f3; d_funct7 = in_instr[31:25];
                d_op1_sel = 1'b1; d_op2_sel = 1'b1; d_wb_sel = 2'b01;
                d_reg_write_en = 1'b1;
                d_illegal = (opcode == 7'h3B) && !IS64;
            end
            7'h17: begin
                d_rd = in_instr[11:7]; d_imm32 = imm_u; d_wb_sel = 2'b01;
                d_reg_write_en = 1'b1;
            end
            7'h37: begin
                d_rd = in_instr[11:7]; d_imm32 = imm_u; d_op1_sel = 1'b1;
                d_wb_sel = 2'b01; d_reg_write_en = 1'b1;
            end
            7'h63: begin
                d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20]; d_funct3 = f3;
                d_imm32 = imm_b; d_op1_sel = 1'b1; d_op2_sel = 1'b1; d_pc_sel = 2'd1;
            end
            7'h6F: begin
                d_rd = in_instr[11:7]; d_imm32 = imm_j; d_wb_sel = 2'b10;
                d_reg_write_en = 1'b1; d_pc_sel = 2'd1;
            end
            7'h67: begin
                d_rd = in_instr[11:7]; d_rs1 = in_instr[19:15]; d_imm32 = imm_i;
                d_op1_sel = 1'b1; d_wb_sel = 2'b10; d_reg_write_en = 1'b1;
                d_pc_sel = 2'd2;
                d_illegal = (f3 != 3'b000);
            end
            7'h73: begin
                d_ecall_break = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
                d_illegal = !d_ecall_break;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
            d_funct3 = 3'd0; d_funct7 = 7'd0; d_imm32 = 32'd0;
            d_op1_sel = 1'b0; d_op2_sel = 1'b0; d_reg_write_en = 1'b0;
            d_wb_sel = 2'b00; d_mem_write = 1'b0; d_sign_ext = 1'b0;
            d_pc_sel = 2'd0; d_ecall_break = 1'b0;
        end
    end

    logic accept;
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register: load on accept, drop on flush or on a consumed bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0; out_pc <= '0;
            out_rd <= 5'd0; out_rs1 <= 5'd0; out_rs2 <= 5'd0;
            out_funct3 <= 3'd0; out_funct7 <= 7'd0; out_imm <= '0;
            out_op1_sel <= 1'b0; out_op2_sel <= 1'b0; out_reg_write_en <= 1'b0;
            out_wb_sel <= 2'b00; out_mem_write <= 1'b0; out_mem_rd_sign_extend <= 1'b0;
            out_pc_sel <= 2'd0; out_ecall_break <= 1'b0; out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1; out_pc <= in_pc;
            out_rd <= d_rd; out_rs1 <= d_rs1; out_rs2 <= d_rs2;
            out_funct3 <= d_funct3; out_funct7 <= d_funct7;
            out_imm <= XLEN'($signed(d_imm32));
            out_op1_sel <= d_op1_sel; out_op2_sel <= d_op2_sel;
            out_reg_write_en <= d_reg_write_en; out_wb_sel <= d_wb_sel;
            out_mem_write <= d_mem_write; out_mem_rd_sign_extend <= d_sign_ext;
            out_pc_sel <= d_pc_sel; out_ecall_break <= d_ecall_break;
            out_illegal <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count illegal bundles as they are consumed, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (out_valid && out_ready && out_illegal &&
                     (illegal_count != {CNT_W{1'b1}})) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives an RV32 instance (2-bit counter) and an RV64
// instance (16-bit counter) with the same directed stream and checks both
// against an instruction-level model on every negative clock edge.
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        op1;
        logic        op2;
        logic        rw;
        logic [1:0]  wb;
        logic        mw;
        logic        sx;
        logic [1:0]  pcs;
        logic        eb;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] in_pc = 64'h0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    logic        r32_in_ready, r32_valid, r32_op1, r32_op2, r32_rw, r32_mw, r32_sx, r32_eb, r32_ill;
    logic [31:0] r32_pc, r32_imm;
    logic [4:0]  r32_rd, r32_rs1, r32_rs2;
    logic [2:0]  r32_f3;
    logic [6:0]  r32_f7;
    logic [1:0]  r32_wb, r32_pcs, r32_cnt;

    logic        r64_in_ready, r64_valid, r64_op1, r64_op2, r64_rw, r64_mw, r64_sx, r64_eb, r64_ill;
    logic [63:0] r64_pc, r64_imm;
    logic [4:0]  r64_rd, r64_rs1, r64_rs2;
    logic [2:0]  r64_f3;
    logic [6:0]  r64_f7;
    logic [1:0]  r64_wb, r64_pcs;
    logic [15:0] r64_cnt;

    decode_stage #(.XLEN(32), .CNT_W(2)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(r32_valid), .out_ready(out_ready), .out_pc(r32_pc),
        .out_rd(r32_rd), .out_rs1(r32_rs1), .out_rs2(r32_rs2),
        .out_funct3(r32_f3), .out_funct7(r32_f7), .out_imm(r32_imm),
        .out_op1_sel(r32_op1), .out_op2_sel(r32_op2), .out_reg_write_en(r32_rw),
        .out_wb_sel(r32_wb), .out_mem_write(r32_mw), .out_mem_rd_sign_extend(r32_sx),
        .out_pc_sel(r32_pcs), .out_ecall_break(r32_eb), .out_illegal(r32_ill),
        .illegal_count(r32_cnt)
    );

    decode_stage #(.XLEN(64), .CNT_W(16)) d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(r64_valid), .out_ready(out_ready), .out_pc(r64_pc),
        .out_rd(r64_rd), .out_rs1(r64_rs1), .out_rs2(r64_rs2),
        .out_funct3(r64_f3), .out_funct7(r64_f7), .out_imm(r64_imm),
        .out_op1_sel(r64_op1), .out_op2_sel(r64_op2), .out_reg_write_en(r64_rw),
        .out_wb_sel(r64_wb), .out_mem_write(r64_mw), .out_mem_rd_sign_extend(r64_sx),
        .out_pc_sel(r64_pcs), .out_ecall_break(r64_eb), .out_illegal(r64_ill),
        .illegal_count(r64_cnt)
    );

    bundle_t a32, a64;
    assign a32 = '{rd: r32_rd, rs1: r32_rs1, rs2: r32_rs2, f3: r32_f3, f7: r32_f7,
                   imm: {32'h0, r32_imm}, op1: r32_op1, op2: r32_op2, rw: r32_rw,
                   wb: r32_wb, mw: r32_mw, sx: r32_sx, pcs: r32_pcs, eb: r32_eb,
                   ill: r32_ill};
    assign a64 = '{rd: r64_rd, rs1: r64_rs1, rs2: r64_rs2, f3: r64_f3, f7: r64_f7,
                   imm: r64_imm, op1: r64_op1, op2: r64_op2, rw: r64_rw,
                   wb: r64_wb, mw: r64_mw, sx: r64_sx, pcs: r64_pcs, eb: r64_eb,
                   ill: r64_ill};

    // Instruction-level meaning of a word: which fields it uses and its immediate.
    function automatic bundle_t model_decode(logic [31:0] i, bit is64);
        bundle_t b;
        logic signed [63:0] s;
        logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [2:0]  f3;
        b = '0;
        f3 = i[14:12];
        s = 64'($signed(i));
        imm_i = 64'(s >>> 20);
        imm_s = 64'((s >>> 25) <<< 5) | 64'(i[11:7]);
        imm_b = 64'((s >>> 31) <<< 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
        imm_u = 64'(s) & ~64'hFFF;
        imm_j = 64'((s >>> 31) <<< 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
        case (i[6:0])
            7'h03: if (f3 != 3'd7 && (is64 || (f3 != 3'd3 && f3 != 3'd6))) begin
                b.rd = i[11:7]; b.rs1 = i[19:15]; b.f3 = f3; b.imm = imm_i;
                b.op1 = 1; b.rw = 1; b.sx = (f3 < 3'd4);
            end else b.ill = 1;
            7'h23: if (f3 <= (is64 ? 3'd3 : 3'd2)) begin
                b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.f3 = f3; b.imm = imm_s;
                b.op1 = 1; b.mw = 1;
            end else b.ill = 1;
            7'h13, 7'h1B: if (is64 || i[6:0] == 7'h13) begin
                b.rd = i[11:7]; b.rs1 = i[19:15]; b.f3 = f3; b.imm = imm_i;
                b.f7 = (f3 == 3'd1 || f3 == 3'd5) ? i[31:25] : 7'd0;
                b.op1 = 1; b.wb = 2'b01; b.rw = 1;
            end else b.ill = 1;
            7'h33, 7'h3B: if (is64 || i[6:0] == 7'h33) begin
                b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.f3 = f3;
                b.f7 = i[31:25]; b.op1 = 1; b.op2 = 1; b.wb = 2'b01; b.rw = 1;
            end else b.ill = 1;
            7'h17: begin b.rd = i[11:7]; b.imm = imm_u; b.wb = 2'b01; b.rw = 1; end
            7'h37: begin b.rd = i[11:7]; b.imm = imm_u; b.op1 = 1; b.wb = 2'b01; b.rw = 1; end
            7'h63: begin
                b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.f3 = f3; b.imm = imm_b;
                b.op1 = 1; b.op2 = 1; b.pcs = 2'd1;
            end
            7'h6F: begin b.rd = i[11:7]; b.imm = imm_j; b.wb = 2'b10; b.rw = 1; b.pcs = 2'd1; end
            7'h67: if (f3 == 3'd0) begin
                b.rd = i[11:7]; b.rs1 = i[19:15]; b.imm = imm_i; b.op1 = 1;
                b.wb = 2'b10; b.rw = 1; b.pcs = 2'd2;
            end else b.ill = 1;
            7'h73: if (i == 32'h0000_0073 || i == 32'h0010_0073) b.eb = 1; else b.ill = 1;
            default: b.ill = 1;
        endcase
        if (!is64) b.imm = {32'h0, b.imm[31:0]};
        return b;
    endfunction

    // Model of the output register: what execute should currently be offered.
    bundle_t     e32 = '0, e64 = '0;
    logic [63:0] epc = 64'h0;
    bit          ev = 0;
    int          cnt32 = 0, cnt64 = 0;

    // Advance the model on each clock edge from the handshake rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ev <= 0; cnt32 <= 0; cnt64 <= 0;
        end else begin
            if (ev && out_ready && e32.ill && cnt32 < 3) cnt32 <= cnt32 + 1;
            if (ev && out_ready && e64.ill && cnt64 < 65535) cnt64 <= cnt64 + 1;
            if (flush) ev <= 0;
            else if (in_valid && (!ev || out_ready)) begin
                ev <= 1; epc <= in_pc;
                e32 <= model_decode(in_instr, 0);
                e64 <= model_decode(in_instr, 1);
            end else if (out_ready) ev <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBundle(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (instr %h)", name, act, exp, in_instr);
        end
    endtask

    // Compare both instances against the model away from the active edge.
    always @(negedge clk) begin
        checkOutput("in_ready32", 64'(r32_in_ready), 64'(!flush && (!ev || out_ready)));
        checkOutput("in_ready64", 64'(r64_in_ready), 64'(!flush && (!ev || out_ready)));
        checkOutput("out_valid32", 64'(r32_valid), 64'(ev));
        checkOutput("out_valid64", 64'(r64_valid), 64'(ev));
        checkOutput("count32", 64'(r32_cnt), 64'(cnt32));
        checkOutput("count64", 64'(r64_cnt), 64'(cnt64));
        if (ev) begin
            checkBundle("bundle32", a32, e32);
            checkBundle("bundle64", a64, e64);
            checkOutput("pc32", 64'(r32_pc), {32'h0, epc[31:0]});
            checkOutput("pc64", r64_pc, epc);
        end
    end

    // Drive one cycle of inputs just after a negedge and return at the next negedge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic rdy, input logic fl);
        #1;
        in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy; flush = fl;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 64'(r32_valid), 64'h0);
        checkOutput("async_rst_count", 64'(r32_cnt), 64'h0);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] words [0:19] = '{
        32'h0002A303, 32'h0002B083, 32'h0002E083, 32'h0000F083, 32'h0002C083,
        32'h00153023, 32'h0000C023, 32'h002081B3, 32'h40208133, 32'h00309093,
        32'h4030D093, 32'h000080E7, 32'h000090E7, 32'hFE208EE3, 32'h00001297,
        32'h00100073, 32'h10500073, 32'h0000007F, 32'h4020813B, 32'hFFF0011B
    };
    int exp_sat [0:5] = '{0, 1, 2, 3, 3, 3};
    int cnt_before;

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 64'(r32_valid), 64'h0);
        checkOutput("rst_imm", 64'(r32_imm), 64'h0);
        checkOutput("rst_rw", 64'(r32_rw), 64'h0);
        checkOutput("rst_count", 64'(r32_cnt), 64'h0);
        checkOutput("rst_in_ready", 64'(r32_in_ready), 64'h1);
        #1 rst = 1'b0;
        @(negedge clk);

        applyStimulus(1, 32'hFFF10093, 64'h100, 1, 0);
        checkOutput("addi_rd", 64'(r32_rd), 64'd1);
        checkOutput("addi_rs1", 64'(r32_rs1), 64'd2);
        checkOutput("addi_imm", 64'(r32_imm), 64'hFFFFFFFF);
        checkOutput("addi_op2", 64'(r32_op2), 64'h0);
        checkOutput("addi_wb", 64'(r32_wb), 64'h1);
        checkOutput("addi_rw", 64'(r32_rw), 64'h1);

        applyStimulus(1, 32'h00532423, 64'h104, 1, 0);
        checkOutput("sw_imm", 64'(r32_imm), 64'd8);
        checkOutput("sw_rs1", 64'(r32_rs1), 64'd6);
        checkOutput("sw_rs2", 64'(r32_rs2), 64'd5);
        checkOutput("sw_mw", 64'(r32_mw), 64'h1);
        checkOutput("sw_rw", 64'(r32_rw), 64'h0);
        checkOutput("sw_rd", 64'(r32_rd), 64'h0);

        applyStimulus(1, 32'h0010009B, 64'h108, 1, 0);
        checkOutput("addiw32_ill", 64'(r32_ill), 64'h1);
        checkOutput("addiw32_rw", 64'(r32_rw), 64'h0);
        checkOutput("addiw64_ill", 64'(r64_ill), 64'h0);
        checkOutput("addiw64_imm", r64_imm, 64'd1);

        applyStimulus(1, 32'h800000B7, 64'h10C, 1, 0);
        checkOutput("lui64_imm", r64_imm, 64'hFFFFFFFF80000000);
        checkOutput("lui32_imm", 64'(r32_imm), 64'h80000000);
        checkOutput("count_after_addiw", 64'(r32_cnt), 64'd1);

        applyStimulus(1, 32'h008000EF, 64'h110, 1, 0);
        checkOutput("jal_imm", 64'(r32_imm), 64'd8);
        checkOutput("jal_wb", 64'(r32_wb), 64'h2);
        checkOutput("jal_pcs", 64'(r32_pcs), 64'h1);

        applyStimulus(1, 32'h00000073, 64'h114, 1, 0);
        checkOutput("ecall_eb", 64'(r32_eb), 64'h1);
        checkOutput("ecall_rw", 64'(r32_rw), 64'h0);

        for (int k = 0; k < 20; k++)
            applyStimulus(1, words[k], 64'h200 + 64'(4 * k), 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        // Backpressure: A held while B waits, then B taken when ready rises.
        applyStimulus(1, 32'h00100093, 64'h300, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 32'h00200113, 64'h304, 0, 0);
            checkOutput("bp_in_ready", 64'(r32_in_ready), 64'h0);
            checkOutput("bp_hold_imm", 64'(r32_imm), 64'd1);
            checkOutput("bp_hold_pc", 64'(r32_pc), 64'h300);
        end
        applyStimulus(1, 32'h00200113, 64'h304, 1, 0);
        checkOutput("bp_second_rd", 64'(r32_rd), 64'd2);
        checkOutput("bp_second_valid", 64'(r32_valid), 64'h1);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);
        checkOutput("bp_drain_valid", 64'(r32_valid), 64'h0);

        // Flush with a legal bundle leaving and an illegal word arriving.
        applyStimulus(1, 32'h00300193, 64'h400, 1, 0);
        cnt_before = cnt32;
        applyStimulus(1, 32'h00000000, 64'h404, 1, 1);
        checkOutput("flush_valid", 64'(r32_valid), 64'h0);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);
        checkOutput("flush_count", 64'(r32_cnt), 64'(cnt_before));

        // Flush while an illegal bundle is consumed still counts it.
        applyStimulus(1, 32'h00000000, 64'h408, 1, 0);
        applyStimulus(1, 32'h00000000, 64'h40C, 1, 1);
        applyStimulus(0, 32'h0, 64'h0, 0, 0);

        // Saturation of the 2-bit counter, then a reset in mid-stream.
        pulseReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k < 5, 32'h00000000, 64'h500 + 64'(4 * k), 1, 0);
            checkOutput("sat_count", 64'(r32_cnt), 64'(exp_sat[k]));
        end
        applyStimulus(1, 32'h00000000, 64'h520, 1, 0);
        pulseReset();
        applyStimulus(0, 32'h0, 64'h0, 1, 0);
        checkOutput("post_rst_count64", 64'(r64_cnt), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32/RV64 instruction decode stage between fetch and execute. It decodes the full RV32I/RV64I base opcode set into the core's control-signal encoding, produces XLEN-wide sign-extended immediates, and flags illegal instructions. Output is held in a single pipeline register behind a valid/ready handshake, with flush support and a saturating illegal-instruction counter.

## Interface
- XLEN, 32: datapath width. 32 or 64; any other value is a elaboration error.
- CNT_W, 16: width of illegal_count.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_instr/in_pc valid.
- in_ready  out  1  stage accepts input this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_funct3  out  3; out_funct7  out  7.
- out_imm  out  XLEN  sign-extended immediate.
- out_op1_sel  out  1  0=PC, 1=rs1.
- out_op2_sel  out  1  0=imm, 1=rs2.
- out_reg_write_en  out  1.
- out_wb_sel  out  2  00=mem, 01=ALU, 10=PC+4.
- out_mem_write  out  1; out_mem_rd_sign_extend  out  1 (1 for LB/LH/LW/LD, 0 for LBU/LHU/LWU).
- out_pc_sel  out  2  0=next, 1=branch/JAL target, 2=JALR target.
- out_ecall_break  out  1  ECALL or EBREAK.
- out_illegal  out  1  instruction not in supported set.
- illegal_count  out  CNT_W  saturating count of illegal instructions delivered.

## Operation
- Decode (opcode hex): 03 load (I-imm, op1 rs1, op2 imm, wb mem, rd write); 23 store (S-imm {i[31:25],i[11:7]}, rs1/rs2, mem_write 1, no rd write); 13 op-imm and 33 op (wb ALU, rd write, funct7 from i[31:25] for 33 and for shifts in 13, else 0); 1B op-imm-32 and 3B op-32 legal only when XLEN=64, else illegal; 17 AUIPC (op1 PC, op2 imm); 37 LUI (rs1 forced 0, op1 rs1, op2 imm); 63 branch (B-imm, rs1/rs2, op2 rs2, pc_sel 1, no rd write); 6F JAL (J-imm, wb PC+4, pc_sel 1); 67 JALR funct3=000 (I-imm, rs1, wb PC+4, pc_sel 2); 73: exactly 0x00000073 or 0x00100073 gives ecall_break 1, no rd write; any other value illegal.
- Unused rs1/rs2/rd fields output 0; unused funct3/funct7 output 0.
- U-imm = {i[31:12],12'b0} sign-extended to XLEN; all other immediates sign-extended from i[31].
- Illegal (unlisted opcode, JALR funct3≠0, load funct3=111 or =011/110 when XLEN=32, store funct3>010 when XLEN=32 or >011 when XLEN=64): out_illegal 1, all register indices, imm, reg_write_en, mem_write, ecall_break, pc_sel = 0; out_pc still valid.
- illegal_count increments on out_valid & out_ready & out_illegal; holds at all-ones.

## Timing
- Reset: out_valid 0, every out_* 0, illegal_count 0; in_ready reflects the combinational rule below.
- in_ready = !flush & (!out_valid | out_ready), combinational.
- Accept when in_valid & in_ready: bundle appears on the next edge with out_valid 1. Latency 1 cycle; full throughput 1/cycle when out_ready held 1.
- out_valid & !out_ready: all out_* held stable, in_ready 0.
- out_valid & out_ready & no accept: out_valid drops next edge.
- flush: out_valid 0 next edge, incoming instruction dropped, no count increment; the flush cycle's handshake on output side still counts if out_ready was 1.
- Reset asserted mid-operation: immediately clears out_valid and counter regardless of handshake.

## Test plan
- XLEN=32, 0xFFF10093 (addi x1,x2,-1) -> next cycle rd 1, rs1 2, imm 0xFFFFFFFF, op2_sel 0, wb 01, reg_write_en 1.
- 0x00532423 (sw x5,8(x6)) -> imm 8, rs1 6, rs2 5, mem_write 1, reg_write_en 0, rd 0.
- XLEN=32, 0x0010009B (addiw) -> out_illegal 1, reg_write_en 0; XLEN=64 same word -> legal, imm 1; XLEN=64, 0x800000B7 (lui) -> imm 0xFFFFFFFF80000000.
- out_ready low 3 cycles with in_valid high on two different words -> in_ready 0, first bundle held stable, second accepted on the cycle out_ready rises, no loss or duplication.
- flush while out_valid 1 and in_valid 1 -> out_valid 0 next cycle, input dropped, illegal_count unchanged.
- CNT_W=2, deliver five illegal words 0x00000000 -> illegal_count 1,2,3,3,3; rst pulse mid-stream -> out_valid and count 0 asynchronously.
